get_certificate_sequencer: RTL and testbench
============================================

// Module: get_certificate_sequencer
// PURPOSE
// - Drives the GET_CERTIFICATE request side of the Type-C authentication driver: reads one slot's certificate chain in chunks.
// - Issues (slot, offset, length) requests to the message builder and checks each responder reply.
// - Chain length is learned from the first reply; offset advances until the whole chain has been read.
// - Handles timeout, bounded retry and error replies; reports done/error to the top-level auth FSM.
// PARAMETERS
// - MAX_CHUNK      default 16'd256  largest length field put in one request (bytes, >=4)
// - MAX_RETRIES    default 2        re-issues allowed per chunk after timeout or error reply
// - TIMEOUT_CYCLES default 4096     clk cycles to wait for a reply before counting a timeout
// PORTS
// - clk            in   1   system clock, all logic on rising edge
// - reset_L        in   1   asynchronous, active-low reset
// - start          in   1   one-cycle pulse: begin chain read; sampled only in IDLE
// - abort          in   1   level: return to IDLE next cycle from any state, no error flagged
// - slot           in   2   certificate slot, captured on start
// - busy           out  1   high in every state except IDLE/DONE/ERR
// - done           out  1   one-cycle pulse: whole chain read
// - error          out  1   one-cycle pulse: read failed; error_code valid same cycle
// - error_code     out  3   1=timeout 2=responder error 3=bad chain length 4=short/long reply; held until next start
// - req_valid      out  1   request fields valid; held until accepted
// - req_ready      in   1   builder accepts request when req_valid&&req_ready
// - req_slot       out  2   slot field of request
// - req_offset     out  16  byte offset into chain
// - req_length     out  16  bytes requested
// - resp_valid     in   1   one-cycle pulse: reply received
// - resp_is_error  in   1   reply is an ERROR message (qualified by resp_valid)
// - resp_bytes     in   16  certificate bytes carried in reply
// - resp_chain_len in  16  Length field of chain header; used only for the offset-0 reply
// - chain_len      out  16  latched total chain length; 0 until first good reply
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, offset/chain_len/retry counter 0, error_code 0.
// - States: IDLE, ISSUE, WAIT, CHECK, DONE, ERR.
// - IDLE: start -> capture slot, offset=0, chain_len=0, retry=0, error_code=0 -> ISSUE.
// - ISSUE: req_valid=1; fields stable while waiting; req_valid&&req_ready -> WAIT, timer cleared.
// - req_length: MAX_CHUNK when offset==0, else min(MAX_CHUNK, chain_len-offset) (16-bit unsigned, no wrap).
// - WAIT: resp_valid -> CHECK (reply registered); timer reaches TIMEOUT_CYCLES-1 -> retry path.
// - resp_valid in the same cycle as timeout: reply wins.
// - CHECK with resp_is_error -> retry path, code 2.
// - CHECK at offset 0: resp_chain_len<4 -> ERR code 3; otherwise latch chain_len.
// - CHECK length check: resp_bytes != req_length -> ERR code 4, except an offset-0 reply where chain_len<MAX_CHUNK and resp_bytes==chain_len.
// - CHECK accept: offset += resp_bytes, retry=0; offset==chain_len -> DONE, else ISSUE.
// - Retry path: retry<MAX_RETRIES -> retry+1, same offset -> ISSUE; else ERR with code 1 (timeout) or 2 (error reply).
// - DONE: done pulse, next cycle IDLE. ERR: error pulse, next cycle IDLE.
// - resp_valid outside WAIT is ignored. start while busy is ignored.
// - abort has priority over every transition; drops req_valid the following cycle.
// - reset_L low mid-read: immediate return to reset values, no done/error pulse.
// - Latency: request issue is 1 cycle after start or after CHECK; CHECK takes 1 cycle.
// STRUCTURE
// - Shared defines header: state encodings, error-code constants, 4-byte minimum chain length, request-type code for GET_CERTIFICATE.
// - Width of req_* fields matches the builder's offset/length field widths.
// - Sub-module auth_resp_timer: counter with clear/enable and expired flag; reused by the other request sequencers.
// TESTING
// - chain_len=600, MAX_CHUNK=256, always ready, exact replies -> requests (0,256),(256,256),(512,88); done after third reply; chain_len=600.
// - chain_len=100, offset-0 reply resp_bytes=100 -> single request, done; no second request.
// - No reply to first request, MAX_RETRIES=2 -> 3 identical requests at offset 0, each TIMEOUT_CYCLES apart; then error, code 1.
// - Error reply on chunk 2, good reply on retry -> offset 256 requested twice, then read continues to done.
// - Offset-0 reply with resp_chain_len=2 -> error code 3; reply with resp_bytes=200 for req_length 256 at offset 256 -> error code 4.
// - Mid-read cases: abort during WAIT -> IDLE next cycle, no pulse; reset_L low during ISSUE -> req_valid=0 at once; start while busy -> ignored.

Source files
------------

// File: rtl/get_certificate_sequencer_pkg.sv
// get_certificate_sequencer_pkg: shared states, error codes and request constants for the cert-chain reader
package get_certificate_sequencer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE, S_ERR} state_t;
  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_RESP = 3'd2;
  localparam logic [2:0] ERR_CHAIN = 3'd3;
  localparam logic [2:0] ERR_SIZE = 3'd4;
  localparam logic [15:0] MIN_CHAIN_LEN = 16'd4;
  localparam logic [7:0] REQ_GET_CERTIFICATE = 8'h82;
  // The first chunk is always a full MAX_CHUNK because chain_len is unknown until its reply.
  function automatic logic [15:0] chunk_len(input logic [15:0] off, input logic [15:0] clen, input logic [15:0] max_chunk);
    logic [15:0] rem;
    rem = (clen > off) ? clen - off : 16'd0;
    return (off == 16'd0) ? max_chunk : ((rem < max_chunk) ? rem : max_chunk);
  endfunction
endpackage

// File: rtl/get_certificate_sequencer_if.sv
// get_certificate_sequencer_if: request/reply channel between a sequencer and the message builder
interface get_certificate_sequencer_if;
  logic req_valid;
  logic req_ready;
  logic [7:0] req_type;
  logic [1:0] req_slot;
  logic [15:0] req_offset;
  logic [15:0] req_length;
  logic resp_valid;
  logic resp_is_error;
  logic [15:0] resp_bytes;
  logic [15:0] resp_chain_len;
  modport master (
    output req_valid, req_type, req_slot, req_offset, req_length,
    input req_ready, resp_valid, resp_is_error, resp_bytes, resp_chain_len
  );
  modport slave (
    input req_valid, req_type, req_slot, req_offset, req_length,
    output req_ready, resp_valid, resp_is_error, resp_bytes, resp_chain_len
  );
endinterface

// File: rtl/get_certificate_sequencer_auth_resp_timer.sv
// auth_resp_timer: reply-wait counter with clear/enable; expired holds until the next clear
module auth_resp_timer #(
  parameter int CYCLES = 4096
) (
  input  logic clk,
  input  logic reset_L,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(CYCLES) + 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en && !expired) cnt <= cnt + W'(1);
  assign expired = cnt == W'(CYCLES - 1);
endmodule

// File: rtl/get_certificate_sequencer.sv
// get_certificate_sequencer: reads one slot's certificate chain in chunks with timeout and bounded retry
module get_certificate_sequencer
  import get_certificate_sequencer_pkg::*;
#(
  parameter logic [15:0] MAX_CHUNK = 16'd256,
  parameter int MAX_RETRIES = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset_L,
  input  logic start,
  input  logic abort,
  input  logic [1:0] slot,
  output logic busy,
  output logic done,
  output logic error,
  output logic [2:0] error_code,
  output logic [15:0] chain_len,
  get_certificate_sequencer_if.master bus
);
  state_t state;
  logic [15:0] offset;
  logic [15:0] len_q;
  logic [7:0] retry;
  logic r_err;
  logic [15:0] r_bytes;
  logic [15:0] r_clen;
  logic t_exp;
  logic [15:0] clen_n;
  logic [16:0] off_n;
  logic len_ok;
  auth_resp_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .reset_L(reset_L),
    .clear(bus.req_valid && bus.req_ready),
    .en(state == S_WAIT),
    .expired(t_exp)
  );
  assign bus.req_type = REQ_GET_CERTIFICATE;
  assign bus.req_offset = offset;
  assign bus.req_length = len_q;
  assign clen_n = (offset == 16'd0) ? r_clen : chain_len;
  assign off_n = {1'b0, offset} + {1'b0, r_bytes};
  // A short first reply is legal only when it carries the whole (sub-chunk) chain.
  assign len_ok = (r_bytes == len_q || (offset == 16'd0 && clen_n < MAX_CHUNK && r_bytes == clen_n))
                  && off_n <= {1'b0, clen_n};
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      error_code <= ERR_NONE;
      chain_len <= '0;
      offset <= '0;
      len_q <= '0;
      retry <= '0;
      r_err <= 1'b0;
      r_bytes <= '0;
      r_clen <= '0;
      bus.req_valid <= 1'b0;
      bus.req_slot <= '0;
    end else if (abort) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      bus.req_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_ISSUE;
          busy <= 1'b1;
          bus.req_valid <= 1'b1;
          bus.req_slot <= slot;
          offset <= '0;
          chain_len <= '0;
          retry <= '0;
          error_code <= ERR_NONE;
          len_q <= MAX_CHUNK;
        end
        S_ISSUE: if (bus.req_ready) begin
          bus.req_valid <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: if (bus.resp_valid) begin
          r_err <= bus.resp_is_error;
          r_bytes <= bus.resp_bytes;
          r_clen <= bus.resp_chain_len;
          state <= S_CHECK;
        end else if (t_exp) begin
          if (retry < 8'(MAX_RETRIES)) begin
            retry <= retry + 8'd1;
            bus.req_valid <= 1'b1;
            state <= S_ISSUE;
          end else begin
            error <= 1'b1;
            error_code <= ERR_TIMEOUT;
            busy <= 1'b0;
            state <= S_ERR;
          end
        end
        S_CHECK: if (r_err) begin
          if (retry < 8'(MAX_RETRIES)) begin
            retry <= retry + 8'd1;
            bus.req_valid <= 1'b1;
            state <= S_ISSUE;
          end else begin
            error <= 1'b1;
            error_code <= ERR_RESP;
            busy <= 1'b0;
            state <= S_ERR;
          end
        end else if (offset == 16'd0 && r_clen < MIN_CHAIN_LEN) begin
          error <= 1'b1;
          error_code <= ERR_CHAIN;
          busy <= 1'b0;
          state <= S_ERR;
        end else begin
          chain_len <= clen_n;
          if (!len_ok) begin
            error <= 1'b1;
            error_code <= ERR_SIZE;
            busy <= 1'b0;
            state <= S_ERR;
          end else begin
            offset <= off_n[15:0];
            retry <= '0;
            if (off_n[15:0] == clen_n) begin
              done <= 1'b1;
              busy <= 1'b0;
              state <= S_DONE;
            end else begin
              len_q <= chunk_len(off_n[15:0], clen_n, MAX_CHUNK);
              bus.req_valid <= 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_get_certificate_sequencer.sv
// tb_get_certificate_sequencer: scoreboard bench; stimulus queues expected requests/outcomes, a monitor checks them
module tb_get_certificate_sequencer;
  typedef struct { logic [1:0] slot; logic [15:0] off; logic [15:0] len; } req_t;
  typedef struct { bit send; bit is_err; logic [15:0] bytes; logic [15:0] clen; } rep_t;
  typedef struct { bit is_err; logic [2:0] code; } evt_t;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [1:0] slot = '0;
  logic busy, done, error;
  logic [2:0] error_code;
  logic [15:0] chain_len;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  req_t exp_req[$];
  rep_t replies[$];
  evt_t exp_evt[$];
  int hs_cyc[$];
  get_certificate_sequencer_if bus ();
  get_certificate_sequencer #(.MAX_CHUNK(16'd256), .MAX_RETRIES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_L(reset_L), .start(start), .abort(abort), .slot(slot),
    .busy(busy), .done(done), .error(error), .error_code(error_code),
    .chain_len(chain_len), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  initial begin : monitor
    req_t r;
    evt_t e;
    forever begin
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_req.size() == 0) chk("unexpected_req", {bus.req_slot, bus.req_offset, bus.req_length}, 0);
        else begin
          r = exp_req.pop_front();
          chk("req", {bus.req_slot, bus.req_offset, bus.req_length}, {r.slot, r.off, r.len});
          chk("req_type", bus.req_type, 8'h82);
        end
      end
      if (done || error) begin
        if (exp_evt.size() == 0) chk("unexpected_evt", {done, error, error_code}, 0);
        else begin
          e = exp_evt.pop_front();
          chk("evt", {done, error, error_code}, {!e.is_err, e.is_err, e.is_err ? e.code : 3'd0});
        end
      end
    end
  end
  initial begin : responder
    rep_t p;
    bit pend = 0;
    bus.resp_valid = 1'b0;
    bus.resp_is_error = 1'b0;
    bus.resp_bytes = '0;
    bus.resp_chain_len = '0;
    forever begin
      @(negedge clk);
      bus.resp_valid = 1'b0;
      if (pend) begin
        bus.resp_valid = 1'b1;
        bus.resp_is_error = p.is_err;
        bus.resp_bytes = p.bytes;
        bus.resp_chain_len = p.clen;
        pend = 0;
      end
      if (bus.req_valid && bus.req_ready && replies.size() != 0) begin
        p = replies.pop_front();
        pend = p.send;
      end
    end
  end
  task automatic pulse_start(input logic [1:0] s);
    @(negedge clk);
    start = 1'b1;
    slot = s;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_end", done || error, 1);
  endtask
  task automatic settle(input string name);
    repeat (3) @(negedge clk);
    chk({name, "_req_left"}, exp_req.size(), 0);
    chk({name, "_evt_left"}, exp_evt.size(), 0);
  endtask
  task automatic add_req(input logic [1:0] s, input logic [15:0] o, input logic [15:0] l);
    exp_req.push_back('{s, o, l});
  endtask
  task automatic add_rep(input bit send, input bit is_err, input logic [15:0] b, input logic [15:0] c);
    replies.push_back('{send, is_err, b, c});
  endtask
  initial begin
    bus.req_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs", {busy, done, error, error_code, chain_len}, 0);
    chk("rst_req", {bus.req_valid, bus.req_offset, bus.req_length}, 0);
    reset_L = 1'b1;
    // 600-byte chain in three chunks, plus a start pulse while busy that must be ignored
    add_req(2, 0, 256); add_req(2, 256, 256); add_req(2, 512, 88);
    add_rep(1, 0, 256, 600); add_rep(1, 0, 256, 0); add_rep(1, 0, 88, 0);
    exp_evt.push_back('{0, 3'd0});
    pulse_start(2);
    chk("busy_on", {busy, bus.req_valid}, 2'b11);
    repeat (2) @(negedge clk);
    pulse_start(0);
    wait_end(200);
    chk("chain600", chain_len, 600);
    chk("busy_done", busy, 0);
    settle("t1");
    // chain shorter than one chunk: single request
    add_req(1, 0, 256);
    add_rep(1, 0, 100, 100);
    exp_evt.push_back('{0, 3'd0});
    pulse_start(1);
    wait_end(100);
    chk("chain100", chain_len, 100);
    settle("t2");
    // no replies: three identical requests spaced by the timeout, then code 1
    hs_cyc.delete();
    repeat (3) add_req(0, 0, 256);
    repeat (3) add_rep(0, 0, 0, 0);
    exp_evt.push_back('{1, 3'd1});
    pulse_start(0);
    wait_end(300);
    settle("t3");
    chk("to_cnt", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3)
      for (int i = 1; i < 3; i++)
        chk("to_gap", (hs_cyc[i] - hs_cyc[i-1] >= TO) && (hs_cyc[i] - hs_cyc[i-1] <= TO + 1), 1);
    // error reply on chunk 2, recovered by retry
    add_req(3, 0, 256); add_req(3, 256, 256); add_req(3, 256, 256); add_req(3, 512, 88);
    add_rep(1, 0, 256, 600); add_rep(1, 1, 0, 0); add_rep(1, 0, 256, 0); add_rep(1, 0, 88, 0);
    exp_evt.push_back('{0, 3'd0});
    pulse_start(3);
    wait_end(200);
    chk("retry_chain", chain_len, 600);
    settle("t4");
    // chain header too short
    add_req(0, 0, 256);
    add_rep(1, 0, 256, 2);
    exp_evt.push_back('{1, 3'd3});
    pulse_start(0);
    wait_end(100);
    chk("badlen_chain", chain_len, 0);
    settle("t5a");
    // short reply on the second chunk
    add_req(0, 0, 256); add_req(0, 256, 256);
    add_rep(1, 0, 256, 600); add_rep(1, 0, 200, 0);
    exp_evt.push_back('{1, 3'd4});
    pulse_start(0);
    wait_end(100);
    settle("t5b");
    chk("code_held", {error_code, chain_len}, {3'd4, 16'd600});
    // abort while waiting for a reply
    add_req(1, 0, 256);
    add_rep(0, 0, 0, 0);
    pulse_start(1);
    repeat (3) @(negedge clk);
    chk("abort_pre", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_post", {busy, bus.req_valid, done, error}, 0);
    repeat (TO + 10) @(negedge clk);
    settle("t6");
    // reset asserted while a request is pending
    bus.req_ready = 1'b0;
    pulse_start(2);
    chk("issue_hold", bus.req_valid, 1);
    #2 reset_L = 1'b0;
    #1 chk("rst_mid", {bus.req_valid, busy, done, error}, 0);
    @(negedge clk);
    reset_L = 1'b1;
    bus.req_ready = 1'b1;
    settle("t7");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
